// File: rtl/lcdi_phase_sched_if.sv
// lcdi_phase_sched_if
// Control/status bundle between the frame/phase scheduler and its environment.
//   frame_start, abort, in_avail, out_ready : requests/flow control into the scheduler
//   phase, phase_en, col, row               : position broadcast to the datapath
//   data_in_valid, data_out_valid           : line-buffer advance / output-RAM write strobes
//   line_end, frame_end, busy, stall_cnt    : progress and status
// master: the environment (drives requests, observes status)
// slave : the scheduler
`timescale 1ns/1ps
interface lcdi_phase_sched_if #(
   parameter int PW = 3,
   parameter int CW = 11
);
   logic          frame_start;
   logic          abort;
   logic          in_avail;
   logic          out_ready;
   logic [PW-1:0] phase;
   logic          phase_en;
   logic [CW-1:0] col;
   logic [CW-1:0] row;
   logic          data_in_valid;
   logic          data_out_valid;
   logic          line_end;
   logic          frame_end;
   logic          busy;
   logic [15:0]   stall_cnt;

   modport master (
      output frame_start, abort, in_avail, out_ready,
      input  phase, phase_en, col, row, data_in_valid, data_out_valid,
             line_end, frame_end, busy, stall_cnt
   );

   modport slave (
      input  frame_start, abort, in_avail, out_ready,
      output phase, phase_en, col, row, data_in_valid, data_out_valid,
             line_end, frame_end, busy, stall_cnt
   );
endinterface

// File: rtl/lcdi_phase_sched.sv
// lcdi_phase_sched
// Frame/phase scheduler for the line-based interpolation pipeline. Steps PHASES
// clock phases per group, walks col over LINE_LEN = IMG_W+FILL groups per line
// and row over a priming row plus IMG_H output rows, and emits registered
// fetch/write/line-end/frame-end strobes. Progress stalls on downstream
// backpressure (out_ready) or, at phase 0 only, on missing input data (in_avail).
// Ports:
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   bus    : lcdi_phase_sched_if.slave (requests in, position/strobes/status out)
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for frame_start; counters held at 0
// ST_RUN  | sequencing a frame; advances on phase_en, else counts stall
`timescale 1ns/1ps
module lcdi_phase_sched #(
   parameter int IMG_W      = 960,
   parameter int IMG_H      = 540,
   parameter int FILL       = 3,
   parameter int PHASES     = 6,
   parameter int OUT_PHASES = 4,
   parameter int CW         = 11,
   parameter int PW         = 3
) (
   input  logic clk,
   input  logic rst_n,
   lcdi_phase_sched_if.slave bus
);

   localparam int LINE_LEN = IMG_W + FILL;

   localparam logic [PW-1:0] LP_PH_LAST  = PW'(PHASES - 1);
   localparam logic [PW-1:0] LP_PH_OUT   = PW'(PHASES - OUT_PHASES);
   localparam logic [CW-1:0] LP_COL_LAST = CW'(LINE_LEN - 1);
   localparam logic [CW-1:0] LP_FILL     = CW'(FILL);
   localparam logic [CW-1:0] LP_IMG_W    = CW'(IMG_W);
   localparam logic [CW-1:0] LP_ROW_LAST = CW'(IMG_H);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t        r_state, w_state_nxt;
   logic [PW-1:0] r_phase, w_phase_nxt;
   logic [CW-1:0] r_col,   w_col_nxt;
   logic [CW-1:0] r_row,   w_row_nxt;
   logic [15:0]   r_stall_cnt, w_stall_nxt;
   logic          r_div, w_div_nxt;
   logic          r_dov, w_dov_nxt;
   logic          r_le,  w_le_nxt;
   logic          r_fe,  w_fe_nxt;

   logic w_phase_en;
   logic w_ph_last;
   logic w_col_last;
   logic w_row_last;

   always_comb begin
      w_ph_last  = (r_phase == LP_PH_LAST);
      w_col_last = (r_col == LP_COL_LAST);
      w_row_last = (r_row == LP_ROW_LAST);
      // in_avail only matters when a new group is about to be fetched (phase 0)
      w_phase_en = (r_state == ST_RUN) && !bus.abort && bus.out_ready &&
                   ((r_phase != '0) || bus.in_avail);

      w_state_nxt = r_state;
      w_phase_nxt = r_phase;
      w_col_nxt   = r_col;
      w_row_nxt   = r_row;
      w_stall_nxt = r_stall_cnt;
      w_div_nxt   = 1'b0;
      w_dov_nxt   = 1'b0;
      w_le_nxt    = 1'b0;
      w_fe_nxt    = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (bus.frame_start && !bus.abort) begin
               w_state_nxt = ST_RUN;
               w_phase_nxt = '0;
               w_col_nxt   = '0;
               w_row_nxt   = '0;
               w_stall_nxt = '0;
            end
         end
         ST_RUN: begin
            if (bus.abort) begin
               // stall_cnt deliberately kept so the aborted frame can be inspected
               w_state_nxt = ST_IDLE;
               w_phase_nxt = '0;
               w_col_nxt   = '0;
               w_row_nxt   = '0;
            end else if (w_phase_en) begin
               w_dov_nxt = (r_phase >= LP_PH_OUT) && (r_row != '0) && (r_col >= LP_FILL);
               w_div_nxt = w_ph_last && !(w_row_last && (r_col >= LP_IMG_W));
               w_le_nxt  = w_ph_last && w_col_last && (r_row != '0);
               w_fe_nxt  = w_ph_last && w_col_last && w_row_last;
               if (w_ph_last) begin
                  w_phase_nxt = '0;
                  if (w_col_last) begin
                     w_col_nxt = '0;
                     if (w_row_last) begin
                        w_row_nxt   = '0;
                        w_state_nxt = ST_IDLE;
                     end else begin
                        w_row_nxt = r_row + CW'(1);
                     end
                  end else begin
                     w_col_nxt = r_col + CW'(1);
                  end
               end else begin
                  w_phase_nxt = r_phase + PW'(1);
               end
            end else if (r_stall_cnt != 16'hFFFF) begin
               w_stall_nxt = r_stall_cnt + 16'd1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_phase_nxt = '0;
            w_col_nxt   = '0;
            w_row_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_phase     <= '0;
         r_col       <= '0;
         r_row       <= '0;
         r_stall_cnt <= '0;
         r_div       <= 1'b0;
         r_dov       <= 1'b0;
         r_le        <= 1'b0;
         r_fe        <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_phase     <= w_phase_nxt;
         r_col       <= w_col_nxt;
         r_row       <= w_row_nxt;
         r_stall_cnt <= w_stall_nxt;
         r_div       <= w_div_nxt;
         r_dov       <= w_dov_nxt;
         r_le        <= w_le_nxt;
         r_fe        <= w_fe_nxt;
      end
   end

   assign bus.phase          = r_phase;
   assign bus.phase_en       = w_phase_en;
   assign bus.col            = r_col;
   assign bus.row            = r_row;
   assign bus.data_in_valid  = r_div;
   assign bus.data_out_valid = r_dov;
   assign bus.line_end       = r_le;
   assign bus.frame_end      = r_fe;
   assign bus.busy           = (r_state == ST_RUN);
   assign bus.stall_cnt      = r_stall_cnt;

endmodule

// File: tb/tb_lcdi_phase_sched.sv
`timescale 1ns/1ps
module tb_lcdi_phase_sched;
   localparam int IMG_W = 4, IMG_H = 2, FILL = 3, PHASES = 6, OUT_PHASES = 4;
   localparam int CW = 11, PW = 3;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   lcdi_phase_sched_if #(.PW(PW), .CW(CW)) bus();

   lcdi_phase_sched #(
      .IMG_W(IMG_W), .IMG_H(IMG_H), .FILL(FILL), .PHASES(PHASES),
      .OUT_PHASES(OUT_PHASES), .CW(CW), .PW(PW)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc, n_dov, n_div, n_le, n_fe, fe_cyc, first_dov, first_div;
   logic fe_busy, fe_le;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, got running expected finished");
      $fatal(1, "watchdog");
   end

   // one cycle; cyc counts sampled edges since the frame_start request
   task automatic tick();
      @(negedge clk);
      cyc++;
      if (bus.data_out_valid) begin
         n_dov++;
         if (first_dov < 0) first_dov = cyc;
      end
      if (bus.data_in_valid) begin
         n_div++;
         if (first_div < 0) first_div = cyc;
      end
      if (bus.line_end) n_le++;
      if (bus.frame_end) begin
         n_fe++;
         fe_cyc  = cyc;
         fe_busy = bus.busy;
         fe_le   = bus.line_end;
      end
   endtask

   task automatic clear_counts();
      cyc = 0; n_dov = 0; n_div = 0; n_le = 0; n_fe = 0;
      fe_cyc = -1; first_dov = -1; first_div = -1; fe_busy = 1'b1; fe_le = 1'b0;
   endtask

   task automatic start_frame(input bit hold);
      bus.frame_start = 1'b1;
      clear_counts();
      tick();
      if (!hold) bus.frame_start = 1'b0;
   endtask

   task automatic wait_fe(input int limit);
      while (n_fe == 0 && cyc < limit) tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.frame_start = 1'b0; bus.abort = 1'b0; bus.in_avail = 1'b1; bus.out_ready = 1'b1;
      #12;
      n_checks++;
      if ({bus.busy, bus.data_out_valid, bus.data_in_valid, bus.line_end, bus.frame_end,
           bus.phase, bus.col, bus.row, bus.stall_cnt} !== '0) begin
         n_fail++;
         $display("FAIL reset_values: busy=%0b phase=%0d col=%0d row=%0d stall=%0d, required all 0",
                  bus.busy, bus.phase, bus.col, bus.row, bus.stall_cnt);
      end
      rst_n = 1'b1;
      clear_counts();
      repeat (3) tick();
      n_checks++;
      if (bus.busy !== 1'b0) begin
         n_fail++; $display("FAIL idle_no_start: busy=%0b required 0", bus.busy);
      end
   endtask

   task automatic test_no_stall();
      start_frame(0);
      n_checks++;
      if (bus.busy !== 1'b1) begin
         n_fail++; $display("FAIL ns_busy_c1: busy=%0b required 1", bus.busy);
      end
      n_checks++;
      if (bus.phase_en !== 1'b1) begin
         n_fail++; $display("FAIL ns_phase_en: got %0b required 1", bus.phase_en);
      end
      tick();
      n_checks++;
      if ({bus.phase, bus.col, bus.row} !== {3'd1, 11'd0, 11'd0}) begin
         n_fail++; $display("FAIL ns_pos_c2: phase=%0d col=%0d row=%0d required 1/0/0", bus.phase, bus.col, bus.row);
      end
      wait_fe(200);
      n_checks++;
      if (fe_cyc !== 127) begin
         n_fail++; $display("FAIL ns_fe_cycle: got %0d required 127", fe_cyc);
      end
      n_checks++;
      if (fe_busy !== 1'b0 || fe_le !== 1'b1) begin
         n_fail++; $display("FAIL ns_fe_busy_le: busy=%0b line_end=%0b required 0/1", fe_busy, fe_le);
      end
      n_checks++;
      if (n_dov !== 32) begin
         n_fail++; $display("FAIL ns_dov_count: got %0d required 32", n_dov);
      end
      n_checks++;
      if (n_div !== 18) begin
         n_fail++; $display("FAIL ns_div_count: got %0d required 18", n_div);
      end
      n_checks++;
      if (n_le !== 2 || n_fe !== 1) begin
         n_fail++; $display("FAIL ns_le_fe_count: line_end=%0d frame_end=%0d required 2/1", n_le, n_fe);
      end
      n_checks++;
      if (first_dov !== 64 || first_div !== 7) begin
         n_fail++; $display("FAIL ns_first_strobes: dov@%0d div@%0d required 64/7", first_dov, first_div);
      end
      n_checks++;
      if (bus.stall_cnt !== 16'd0) begin
         n_fail++; $display("FAIL ns_stall: got %0d required 0", bus.stall_cnt);
      end
   endtask

   task automatic test_out_ready_stall();
      start_frame(0);
      while (!(bus.row == 1 && bus.col == 4 && bus.phase == 3) && cyc < 200) tick();
      n_checks++;
      if (cyc !== 70) begin
         n_fail++; $display("FAIL or_reach: got cycle %0d required 70", cyc);
      end
      bus.out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_checks++;
         if ({bus.phase, bus.col, bus.row} !== {3'd3, 11'd4, 11'd1}) begin
            n_fail++; $display("FAIL or_frozen[%0d]: phase=%0d col=%0d row=%0d required 3/4/1", i, bus.phase, bus.col, bus.row);
         end
         n_checks++;
         if ({bus.data_out_valid, bus.data_in_valid, bus.line_end, bus.frame_end, bus.phase_en} !== 5'b0) begin
            n_fail++; $display("FAIL or_no_strobe[%0d]: dov=%0b div=%0b le=%0b fe=%0b en=%0b required 0", i,
                               bus.data_out_valid, bus.data_in_valid, bus.line_end, bus.frame_end, bus.phase_en);
         end
      end
      bus.out_ready = 1'b1;
      n_checks++;
      if (bus.stall_cnt !== 16'd5) begin
         n_fail++; $display("FAIL or_stall_cnt: got %0d required 5", bus.stall_cnt);
      end
      wait_fe(250);
      n_checks++;
      if (fe_cyc !== 132) begin
         n_fail++; $display("FAIL or_fe_cycle: got %0d required 132", fe_cyc);
      end
      n_checks++;
      if (n_dov !== 32 || n_div !== 18 || n_le !== 2) begin
         n_fail++; $display("FAIL or_counts: dov=%0d div=%0d le=%0d required 32/18/2", n_dov, n_div, n_le);
      end
      n_checks++;
      if (bus.stall_cnt !== 16'd5) begin
         n_fail++; $display("FAIL or_stall_end: got %0d required 5", bus.stall_cnt);
      end
   endtask

   task automatic test_in_avail_stall();
      start_frame(0);
      while (!(bus.phase == 0 && bus.col == 1 && bus.row == 0) && cyc < 200) tick();
      n_checks++;
      if (cyc !== 7) begin
         n_fail++; $display("FAIL ia_reach: got cycle %0d required 7", cyc);
      end
      bus.in_avail = 1'b0;
      #1;
      n_checks++;
      if (bus.phase_en !== 1'b0) begin
         n_fail++; $display("FAIL ia_phase_en: got %0b required 0", bus.phase_en);
      end
      repeat (3) tick();
      n_checks++;
      if ({bus.phase, bus.col} !== {3'd0, 11'd1}) begin
         n_fail++; $display("FAIL ia_frozen: phase=%0d col=%0d required 0/1", bus.phase, bus.col);
      end
      bus.in_avail = 1'b1;
      n_checks++;
      if (bus.stall_cnt !== 16'd3) begin
         n_fail++; $display("FAIL ia_stall_cnt: got %0d required 3", bus.stall_cnt);
      end
      while (bus.phase != 3 && cyc < 200) tick();
      bus.in_avail = 1'b0;
      tick();
      tick();
      n_checks++;
      if (bus.phase !== 3'd5) begin
         n_fail++; $display("FAIL ia_mid_group: phase=%0d required 5", bus.phase);
      end
      bus.in_avail = 1'b1;
      wait_fe(250);
      n_checks++;
      if (fe_cyc !== 130 || bus.stall_cnt !== 16'd3) begin
         n_fail++; $display("FAIL ia_fe: cycle=%0d stall=%0d required 130/3", fe_cyc, bus.stall_cnt);
      end
   endtask

   task automatic test_abort();
      start_frame(0);
      while (!(bus.row == 1 && bus.col == 5 && bus.phase == 2) && cyc < 200) tick();
      n_checks++;
      if (cyc !== 75) begin
         n_fail++; $display("FAIL ab_reach: got cycle %0d required 75", cyc);
      end
      bus.out_ready = 1'b0;
      repeat (2) tick();
      bus.out_ready = 1'b1;
      tick();
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      n_checks++;
      if ({bus.busy, bus.phase, bus.col, bus.row} !== '0) begin
         n_fail++; $display("FAIL ab_idle: busy=%0b phase=%0d col=%0d row=%0d required 0", bus.busy, bus.phase, bus.col, bus.row);
      end
      n_checks++;
      if ({bus.data_out_valid, bus.data_in_valid, bus.line_end, bus.frame_end} !== 4'b0) begin
         n_fail++; $display("FAIL ab_strobes: dov=%0b div=%0b le=%0b fe=%0b required 0",
                            bus.data_out_valid, bus.data_in_valid, bus.line_end, bus.frame_end);
      end
      n_checks++;
      if (bus.stall_cnt !== 16'd2) begin
         n_fail++; $display("FAIL ab_stall_hold: got %0d required 2", bus.stall_cnt);
      end
      repeat (20) tick();
      n_checks++;
      if (n_fe !== 0 || bus.busy !== 1'b0) begin
         n_fail++; $display("FAIL ab_no_fe: frame_end=%0d busy=%0b required 0/0", n_fe, bus.busy);
      end
      start_frame(0);
      wait_fe(200);
      n_checks++;
      if (fe_cyc !== 127 || n_dov !== 32 || n_div !== 18 || n_le !== 2 || bus.stall_cnt !== 16'd0) begin
         n_fail++; $display("FAIL ab_clean_frame: fe@%0d dov=%0d div=%0d le=%0d stall=%0d required 127/32/18/2/0",
                            fe_cyc, n_dov, n_div, n_le, bus.stall_cnt);
      end
   endtask

   task automatic test_back_to_back();
      start_frame(1);
      while (cyc < 127) tick();
      n_checks++;
      if (fe_cyc !== 127 || bus.busy !== 1'b0) begin
         n_fail++; $display("FAIL b2b_first: fe@%0d busy=%0b required 127/0", fe_cyc, bus.busy);
      end
      tick();
      n_checks++;
      if (bus.busy !== 1'b1) begin
         n_fail++; $display("FAIL b2b_restart: busy=%0b required 1", bus.busy);
      end
      while (cyc < 254) tick();
      bus.frame_start = 1'b0;
      n_checks++;
      if (fe_cyc !== 254 || n_fe !== 2) begin
         n_fail++; $display("FAIL b2b_second: fe@%0d count=%0d required 254/2", fe_cyc, n_fe);
      end
      repeat (3) tick();
      n_checks++;
      if (bus.busy !== 1'b0 || n_fe !== 2) begin
         n_fail++; $display("FAIL b2b_stop: busy=%0b count=%0d required 0/2", bus.busy, n_fe);
      end
   endtask

   task automatic test_async_reset();
      start_frame(0);
      while (cyc < 40) begin
         bus.out_ready = (cyc == 10 || cyc == 11) ? 1'b0 : 1'b1;
         tick();
      end
      bus.out_ready = 1'b1;
      n_checks++;
      if (bus.stall_cnt !== 16'd2 || bus.busy !== 1'b1) begin
         n_fail++; $display("FAIL ar_pre: stall=%0d busy=%0b required 2/1", bus.stall_cnt, bus.busy);
      end
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({bus.busy, bus.data_out_valid, bus.data_in_valid, bus.line_end, bus.frame_end,
           bus.phase, bus.col, bus.row, bus.stall_cnt} !== '0) begin
         n_fail++; $display("FAIL ar_async: busy=%0b phase=%0d col=%0d row=%0d stall=%0d required all 0",
                            bus.busy, bus.phase, bus.col, bus.row, bus.stall_cnt);
      end
      #3 rst_n = 1'b1;
      clear_counts();
      repeat (10) tick();
      n_checks++;
      if (n_dov + n_div + n_le + n_fe !== 0 || bus.busy !== 1'b0) begin
         n_fail++; $display("FAIL ar_quiet: strobes=%0d busy=%0b required 0/0", n_dov + n_div + n_le + n_fe, bus.busy);
      end
      start_frame(0);
      n_checks++;
      if (bus.busy !== 1'b1) begin
         n_fail++; $display("FAIL ar_restart: busy=%0b required 1", bus.busy);
      end
   endtask

   initial begin
      test_reset();
      test_no_stall();
      test_out_ready_stall();
      test_in_avail_stall();
      test_abort();
      test_back_to_back();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
